// File: rtl/gpu_pkg.sv
// Shared types for the triangle scheduler: screen vectors, triangle descriptors, FSM states.
package gpu_pkg;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } vec2_t;

  typedef struct packed {
    vec2_t v0;
    vec2_t v1;
    vec2_t v2;
  } tri_t;

  typedef enum logic [2:0] {
    StIdle,
    StBbox,
    StCull,
    StLaunch,
    StWait
  } state_e;

  // Coordinates are guaranteed to lie in [-COORD_LIMIT, COORD_LIMIT-1].
  localparam int COORD_LIMIT = 16384;

  function automatic logic signed [63:0] sext64(input logic [31:0] a);
    return {{32{a[31]}}, a};
  endfunction

  function automatic logic signed [31:0] smin3(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input logic signed [31:0] c);
    logic signed [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [31:0] smax3(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input logic signed [31:0] c);
    logic signed [31:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpu_tri_fifo.sv
// Synchronous FIFO of triangle descriptors; push when full and pop when empty are ignored.
module gpu_tri_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic [$bits(tri_t)-1:0]  i_data,
  input  logic                     i_pop,
  output logic [$bits(tri_t)-1:0]  o_data,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [$bits(tri_t)-1:0] mem_q [DEPTH];
  logic push_en, pop_en;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = i_push && !o_full;
  assign pop_en  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge i_clock) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/gpu_triangle_scheduler.sv
// Triangle scheduler: buffers triangles, computes clamped bbox and signed area, culls
// back-facing/degenerate/off-screen triangles, launches the rasterizer and holds operands.
module gpu_triangle_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int          FB_WIDTH   = 640,
  parameter int          FB_HEIGHT  = 480,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_tri_valid,
  output logic               o_tri_ready,
  input  logic [191:0]       i_tri,
  output logic               o_rast_request,
  input  logic               i_rast_ready,
  output logic [63:0]        o_rast_min,
  output logic [63:0]        o_rast_max,
  output logic [63:0]        o_rast_v0,
  output logic [63:0]        o_rast_v1,
  output logic [63:0]        o_rast_v2,
  output logic               o_idle,
  output logic [COUNT_W-1:0] o_drawn_count,
  output logic [COUNT_W-1:0] o_culled_count
);

  localparam logic signed [31:0] XMax = 32'(FB_WIDTH - 1);
  localparam logic signed [31:0] YMax = 32'(FB_HEIGHT - 1);

  state_e             state_q, state_d;
  tri_t               tri_q, tri_d;
  vec2_t              raw_min_q, raw_min_d;
  vec2_t              raw_max_q, raw_max_d;
  logic signed [63:0] area_q, area_d;
  vec2_t              rast_min_q, rast_min_d;
  vec2_t              rast_max_q, rast_max_d;
  logic [COUNT_W-1:0] drawn_q, drawn_d;
  logic [COUNT_W-1:0] culled_q, culled_d;

  logic [191:0] fifo_head;
  logic         fifo_pop, fifo_full, fifo_empty;

  gpu_tri_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_push    (i_tri_valid),
    .i_data    (i_tri),
    .i_pop     (fifo_pop),
    .o_data    (fifo_head),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  // Bounding box and signed area of the held triangle (positive = front-facing).
  vec2_t              bb_min, bb_max;
  logic signed [63:0] d1x, d1y, d2x, d2y, area_c;

  assign bb_min.x = smin3(tri_q.v0.x, tri_q.v1.x, tri_q.v2.x);
  assign bb_min.y = smin3(tri_q.v0.y, tri_q.v1.y, tri_q.v2.y);
  assign bb_max.x = smax3(tri_q.v0.x, tri_q.v1.x, tri_q.v2.x);
  assign bb_max.y = smax3(tri_q.v0.y, tri_q.v1.y, tri_q.v2.y);

  assign d1x    = sext64(tri_q.v1.x) - sext64(tri_q.v0.x);
  assign d1y    = sext64(tri_q.v1.y) - sext64(tri_q.v0.y);
  assign d2x    = sext64(tri_q.v2.x) - sext64(tri_q.v0.x);
  assign d2y    = sext64(tri_q.v2.y) - sext64(tri_q.v0.y);
  assign area_c = (d1x * d2y) - (d1y * d2x);

  // Cull decision and screen clamp from the registered bbox/area.
  logic  cull_c;
  vec2_t clamp_min, clamp_max;

  assign cull_c = (area_q <= 64'sd0) ||
                  ($signed(raw_max_q.x) < 32'sd0) || ($signed(raw_max_q.y) < 32'sd0) ||
                  ($signed(raw_min_q.x) > XMax)   || ($signed(raw_min_q.y) > YMax);

  assign clamp_min.x = ($signed(raw_min_q.x) < 32'sd0) ? 32'sd0 : raw_min_q.x;
  assign clamp_min.y = ($signed(raw_min_q.y) < 32'sd0) ? 32'sd0 : raw_min_q.y;
  assign clamp_max.x = ($signed(raw_max_q.x) > XMax) ? XMax : raw_max_q.x;
  assign clamp_max.y = ($signed(raw_max_q.y) > YMax) ? YMax : raw_max_q.y;

  // Next-state logic: one triangle in flight from pop until rasterizer completion.
  always_comb begin
    state_d    = state_q;
    tri_d      = tri_q;
    raw_min_d  = raw_min_q;
    raw_max_d  = raw_max_q;
    area_d     = area_q;
    rast_min_d = rast_min_q;
    rast_max_d = rast_max_q;
    drawn_d    = drawn_q;
    culled_d   = culled_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          tri_d    = fifo_head;
          state_d  = StBbox;
        end
      end
      StBbox: begin
        raw_min_d = bb_min;
        raw_max_d = bb_max;
        area_d    = area_c;
        state_d   = StCull;
      end
      StCull: begin
        if (cull_c) begin
          culled_d = culled_q + 1'b1;
          state_d  = StIdle;
        end else begin
          rast_min_d = clamp_min;
          rast_max_d = clamp_max;
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWait;
      end
      StWait: begin
        if (i_rast_ready) begin
          drawn_d = drawn_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      tri_q      <= '0;
      raw_min_q  <= '0;
      raw_max_q  <= '0;
      area_q     <= '0;
      rast_min_q <= '0;
      rast_max_q <= '0;
      drawn_q    <= '0;
      culled_q   <= '0;
    end else begin
      state_q    <= state_d;
      tri_q      <= tri_d;
      raw_min_q  <= raw_min_d;
      raw_max_q  <= raw_max_d;
      area_q     <= area_d;
      rast_min_q <= rast_min_d;
      rast_max_q <= rast_max_d;
      drawn_q    <= drawn_d;
      culled_q   <= culled_d;
    end
  end

  assign o_tri_ready    = !fifo_full;
  assign o_rast_request = (state_q == StLaunch);
  assign o_rast_min     = rast_min_q;
  assign o_rast_max     = rast_max_q;
  assign o_rast_v0      = tri_q.v0;
  assign o_rast_v1      = tri_q.v1;
  assign o_rast_v2      = tri_q.v2;
  assign o_idle         = fifo_empty && (state_q == StIdle);
  assign o_drawn_count  = drawn_q;
  assign o_culled_count = culled_q;

endmodule

// File: tb/tb_gpu_triangle_scheduler.sv
// Bench for gpu_triangle_scheduler: queue-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_gpu_triangle_scheduler;
  import gpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int FBW   = 640;
  localparam int FBH   = 480;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tri_valid = 1'b0;
  logic [191:0]  tri_in = '0;
  logic          rast_ready = 1'b0;
  logic          tri_ready, rast_request, idle;
  logic [63:0]   rast_min, rast_max, rast_v0, rast_v1, rast_v2;
  logic [CW-1:0] drawn_count, culled_count;

  always #5 clk = ~clk;

  gpu_triangle_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .FB_WIDTH   (FBW),
    .FB_HEIGHT  (FBH),
    .COUNT_W    (CW)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_tri_valid    (tri_valid),
    .o_tri_ready    (tri_ready),
    .i_tri          (tri_in),
    .o_rast_request (rast_request),
    .i_rast_ready   (rast_ready),
    .o_rast_min     (rast_min),
    .o_rast_max     (rast_max),
    .o_rast_v0      (rast_v0),
    .o_rast_v1      (rast_v1),
    .o_rast_v2      (rast_v2),
    .o_idle         (idle),
    .o_drawn_count  (drawn_count),
    .o_culled_count (culled_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_cnt  = 0;
  int last_req_cyc = 0;
  int push_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tri_t mk(input int ax, input int ay, input int bx, input int by,
                              input int cx, input int cy);
    tri_t t;
    t.v0.x = ax; t.v0.y = ay;
    t.v1.x = bx; t.v1.y = by;
    t.v2.x = cx; t.v2.y = cy;
    return t;
  endfunction

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // ---------------- behavioural model ----------------
  // A queue of waiting triangles plus one in-flight triangle whose progress is counted in
  // cycles since its pop: 1 bbox, 2 cull decision, 3 launch, 4+ waiting for completion.
  tri_t        q[$];
  bit          busy = 0;
  int          age = 0;
  tri_t        m_v = '0;
  logic [63:0] m_min = '0;
  logic [63:0] m_max = '0;
  int          m_drawn = 0;
  int          m_culled = 0;

  always @(negedge rst_n) begin
    q.delete();
    busy = 0; age = 0; m_v = '0; m_min = '0; m_max = '0; m_drawn = 0; m_culled = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit     acc;
      int     x0, y0, x1, y1, x2, y2, mnx, mny, mxx, mxy;
      longint area;
      acc = tri_valid && (q.size() < DEPTH);
      if (!busy) begin
        if (q.size() > 0) begin
          m_v  = q.pop_front();
          busy = 1;
          age  = 1;
        end
      end else begin
        case (age)
          1: age = 2;
          2: begin
            x0 = m_v.v0.x; y0 = m_v.v0.y;
            x1 = m_v.v1.x; y1 = m_v.v1.y;
            x2 = m_v.v2.x; y2 = m_v.v2.y;
            area = longint'(x1 - x0) * longint'(y2 - y0) - longint'(y1 - y0) * longint'(x2 - x0);
            mnx = imin3(x0, x1, x2); mny = imin3(y0, y1, y2);
            mxx = imax3(x0, x1, x2); mxy = imax3(y0, y1, y2);
            if (area <= 0 || mxx < 0 || mxy < 0 || mnx > FBW - 1 || mny > FBH - 1) begin
              m_culled++;
              busy = 0;
            end else begin
              m_min = {32'(mnx < 0 ? 0 : mnx), 32'(mny < 0 ? 0 : mny)};
              m_max = {32'(mxx > FBW - 1 ? FBW - 1 : mxx), 32'(mxy > FBH - 1 ? FBH - 1 : mxy)};
              age = 3;
            end
          end
          3: age = 4;
          default: begin
            if (rast_ready) begin
              m_drawn++;
              busy = 0;
            end
          end
        endcase
      end
      if (acc) q.push_back(tri_in);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst_n) begin
      check("tri_ready",    {63'd0, tri_ready},    {63'd0, q.size() < DEPTH});
      check("rast_request", {63'd0, rast_request}, {63'd0, busy && age == 3});
      check("idle",         {63'd0, idle},         {63'd0, !busy && q.size() == 0});
      check("rast_v0",      rast_v0,  m_v.v0);
      check("rast_v1",      rast_v1,  m_v.v1);
      check("rast_v2",      rast_v2,  m_v.v2);
      check("rast_min",     rast_min, m_min);
      check("rast_max",     rast_max, m_max);
      check("drawn_count",  {48'd0, drawn_count},  {48'd0, 16'(m_drawn)});
      check("culled_count", {48'd0, culled_count}, {48'd0, 16'(m_culled)});
      if (rast_request) begin
        req_cnt++;
        last_req_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic push(input tri_t t);
    int n;
    n = 0;
    if (t.v0.x >= COORD_LIMIT || t.v1.x >= COORD_LIMIT || t.v2.x >= COORD_LIMIT) begin
      $display("FAIL stimulus: coordinate outside contract");
      $fatal(1);
    end
    tri_valid = 1'b1;
    tri_in    = t;
    while (!tri_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tri_ready) begin
      check("push_accept_timeout", {63'd0, tri_ready}, 64'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
      push_cyc = cyc;
    end
    tri_valid = 1'b0;
  endtask

  task automatic wait_req(input int target);
    int n;
    n = 0;
    while (req_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("request_seen_timeout", {63'd0, req_cnt >= target}, 64'd1);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    rast_ready = 1'b1;
    @(negedge clk);
    rast_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tri_ready", {63'd0, tri_ready}, 64'd1);
    check("reset_idle",      {63'd0, idle},      64'd1);
    check("reset_drawn",     {48'd0, drawn_count}, 64'd0);
    check("reset_rast_min",  rast_min, 64'd0);

    // Front-facing right triangle: launch 3 cycles after the pop.
    r0 = req_cnt;
    push(mk(0, 0, 4, 0, 0, 4));
    wait_req(r0 + 1);
    check("t1_latency", 64'(last_req_cyc - push_cyc), 64'd3);
    check("t1_min", rast_min, {32'd0, 32'd0});
    check("t1_max", rast_max, {32'd4, 32'd4});
    pulse_ready();
    repeat (2) @(negedge clk);
    check("t1_drawn", {48'd0, drawn_count}, 64'd1);
    check("t1_idle",  {63'd0, idle}, 64'd1);
    check("t1_pulses", 64'(req_cnt - r0), 64'd1);

    // Back-facing (area -16) and degenerate (area 0).
    r0 = req_cnt;
    push(mk(0, 0, 0, 4, 4, 0));
    push(mk(0, 0, 2, 2, 4, 4));
    repeat (8) @(negedge clk);
    check("t2_no_request", 64'(req_cnt - r0), 64'd0);
    check("t2_culled", {48'd0, culled_count}, 64'd2);

    // Partly off-screen: clamped to the framebuffer.
    r0 = req_cnt;
    push(mk(-5, -3, 700, 10, 10, 500));
    wait_req(r0 + 1);
    check("t3_min", rast_min, {32'd0, 32'd0});
    check("t3_max", rast_max, {32'd639, 32'd479});
    pulse_ready();
    repeat (2) @(negedge clk);
    check("t3_drawn", {48'd0, drawn_count}, 64'd2);

    // Entirely right of the screen.
    r0 = req_cnt;
    push(mk(650, 0, 660, 0, 650, 10));
    repeat (8) @(negedge clk);
    check("t4_no_request", 64'(req_cnt - r0), 64'd0);
    check("t4_culled", {48'd0, culled_count}, 64'd3);

    // Back-pressure: 1 in flight + 4 buffered, 6th waits; drain in order.
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) push(mk(0, 0, 4 + i, 0, 0, 4 + i));
    check("t5_full_after_5", {63'd0, tri_ready}, 64'd0);
    fork
      push(mk(0, 0, 9, 0, 0, 9));
      begin
        for (int k = 0; k < 6; k++) begin
          wait_req(r0 + k + 1);
          if (k == 0) begin
            repeat (5) @(negedge clk);
            check("t5_hold_v1", rast_v1, {32'd4, 32'd0});
            check("t5_hold_max", rast_max, {32'd4, 32'd4});
          end
          if (k == 5) check("t5_last_v2", rast_v2, {32'd0, 32'd9});
          pulse_ready();
        end
      end
    join
    repeat (3) @(negedge clk);
    check("t5_drawn", {48'd0, drawn_count}, 64'd8);
    check("t5_pulses", 64'(req_cnt - r0), 64'd6);
    check("t5_idle", {63'd0, idle}, 64'd1);

    // Asynchronous reset in the middle of WAIT with a triangle still buffered.
    r0 = req_cnt;
    push(mk(1, 1, 20, 1, 1, 20));
    push(mk(2, 2, 30, 2, 2, 30));
    wait_req(r0 + 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_request", {63'd0, rast_request}, 64'd0);
    check("rst_v0",      rast_v0, 64'd0);
    check("rst_min",     rast_min, 64'd0);
    check("rst_max",     rast_max, 64'd0);
    check("rst_drawn",   {48'd0, drawn_count}, 64'd0);
    check("rst_culled",  {48'd0, culled_count}, 64'd0);
    check("rst_idle",    {63'd0, idle}, 64'd1);
    check("rst_ready",   {63'd0, tri_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = req_cnt;
    repeat (10) @(negedge clk);
    check("rst_no_request", 64'(req_cnt - r0), 64'd0);
    check("rst_idle_after", {63'd0, idle}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
